ag_video_fetch: RTL and testbench
=================================

// Module: ag_video_fetch
// PURPOSE
//  Video-side consumer of the 32Kx8/16 dual-port video RAM's second port (CLK2/AB2/CS2/DO2).
//  Generates raster timing, issues one 16-bit word fetch per display word with correct sync-RAM latency,
//  serialises words into pixels (1bpp mono / 2bpp colour) and drives blank/sync to the video DAC stage.
// PARAMETERS
//  H_ACTIVE   256  visible pixels per line
//  H_TOTAL    384  pixels per line incl. blanking (must satisfy H_TOTAL-4 >= H_ACTIVE)
//  H_SYNC_ST  296  first h of HSYNC_N low
//  H_SYNC_LEN 32   HSYNC_N low width, pixels
//  V_ACTIVE   256  visible lines
//  V_TOTAL    312  lines per frame
//  V_SYNC_ST  272  first line of VSYNC_N low
//  V_SYNC_LEN 4    VSYNC_N low width, lines
// PORTS
//  CLK         in   1   pixel clock; also drives RAM port 2 (CLK2)
//  RST_N       in   1   synchronous active-low reset
//  MODE        in   1   0 = 1bpp (16 px/word), 1 = 2bpp (8 px/word)
//  PAGE        in   2   display page select
//  AB2         out  14  RAM port 2 word address
//  CS2         out  1   RAM port 2 enable (1-cycle pulse per fetch)
//  DO2         in   16  RAM port 2 data, valid the cycle after CS2
//  PIX         out  2   pixel value (1bpp: PIX[1]=0)
//  BLANK       out  1   1 outside active area; PIX forced 0 when 1
//  HSYNC_N     out  1   horizontal sync, active low
//  VSYNC_N     out  1   vertical sync, active low
//  FRAME_START out  1   1-cycle pulse when (h,v)=(0,0)
// BEHAVIOUR
//  Reset (RST_N=0 at edge): h=H_TOTAL-4, v=V_TOTAL-1; CS2=0, AB2=0, shifter=0, PIX=0, BLANK=1, HSYNC_N=1,
//   VSYNC_N=1, FRAME_START=0; MODE/PAGE latches=0. Reset mid-line/mid-fetch abandons fetch, no partial load.
//  Counters: h 0..H_TOTAL-1; at wrap h=0 and v increments; v wraps V_TOTAL-1 -> 0.
//  All outputs registered; they describe the current (h,v). BLANK = !(h<H_ACTIVE && v<V_ACTIVE).
//  HSYNC_N=0 iff H_SYNC_ST<=h<H_SYNC_ST+H_SYNC_LEN; VSYNC_N=0 iff V_SYNC_ST<=v<V_SYNC_ST+V_SYNC_LEN.
//  W = 16 (MODE 0) or 8 (MODE 1). Fetch runs 2 cycles ahead: fetch position f=(h+2) mod H_TOTAL, line fl = v,
//   or v+1 (mod V_TOTAL) when f wrapped. In cycle c where f<H_ACTIVE, fl<V_ACTIVE, f%W==0: CS2=1 in c,
//   AB2 = MODE0: {PAGE[1:0], fl[7:0], f[7:4]}; MODE1: {PAGE[0], fl[7:0], f[7:3]}.
//   DO2 captured at end of c+1 into shifter; first pixel of word shown in c+2 (h%W==0). Else CS2=0, AB2 holds.
//  Pixel order: even byte DO2[7:0] first, MSB first, then DO2[15:8] MSB first.
//   MODE0: DO2[7],..,DO2[0],DO2[15],..,DO2[8]. MODE1 pairs: DO2[7:6],[5:4],[3:2],[1:0],[15:14],..,[9:8].
//  MODE and PAGE latched once per frame in the cycle issuing the frame's first fetch (h=H_TOTAL-2, v=V_TOTAL-1);
//   mid-frame changes take effect next frame. The latched values govern both address and shifter width.
//  After reset, frame begins 4 cycles later at (0,0) with a complete first word (prefetch not missed).
//  Shifter holds (shifts zeros) during blanking; no fetch outside active window.
// STRUCTURE
//  Header ag_video_defs.vh: default timing constants, MODE_1BPP=0/MODE_2BPP=1 codes, address-field widths.
//  One sub-module: ag_video_shifter (16-bit load, 1- or 2-bit shift, byte-swapped order, zero fill).
//  Top holds h/v counters, fetch scheduler, MODE/PAGE frame latch, sync/blank registers.
// TESTING
//  Reset release: FRAME_START pulses exactly 4 cycles later; first CS2 at h=H_TOTAL-2,v=V_TOTAL-1, AB2=0.
//  MODE0, PAGE=2, RAM model word at 0x2000 = 16'hA55A: line 0 PIX[0] for h=0..15 = 0,1,0,1,1,0,1,0,1,0,1,0,0,1,0,1.
//  MODE1, PAGE=1, word 0x2000 = 16'h1BE4: line 0 PIX h=0..7 = 3,2,1,0,0,1,2,3; CS2 every 8 cycles, 32 per line.
//  Line 255 last fetch AB2 = {PAGE,8'hFF,4'hF} (MODE0); no CS2 for lines 256..V_TOTAL-2; BLANK=1, PIX=0 there.
//  Toggle MODE at v=100: address/pixel width unchanged until next FRAME_START, then switches.
//  Assert RST_N=0 for 1 cycle at h=50,v=10: all outputs at reset values next cycle; clean frame thereafter;
//   HSYNC_N low exactly 32 cycles/line, VSYNC_N low exactly 4*H_TOTAL cycles/frame.

Source files
------------

// File: rtl/ag_video_fetch_pkg.sv
// Shared constants for the video fetch slice: default raster timing,
// pixel-mode codes, RAM port-2 widths and a counter-width helper.
package ag_video_fetch_pkg;

    localparam int unsigned H_ACTIVE_DEF   = 256;
    localparam int unsigned H_TOTAL_DEF    = 384;
    localparam int unsigned H_SYNC_ST_DEF  = 296;
    localparam int unsigned H_SYNC_LEN_DEF = 32;
    localparam int unsigned V_ACTIVE_DEF   = 256;
    localparam int unsigned V_TOTAL_DEF    = 312;
    localparam int unsigned V_SYNC_ST_DEF  = 272;
    localparam int unsigned V_SYNC_LEN_DEF = 4;

    localparam logic MODE_1BPP = 1'b0;
    localparam logic MODE_2BPP = 1'b1;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;

    // Counters are at least 8 bits wide so the fixed address fields
    // (line[7:0], position[7:3]) can always be sliced.
    function automatic int unsigned cnt_width(input int unsigned total);
        return ($clog2(total) < 8) ? 8 : $clog2(total);
    endfunction

endpackage

// File: rtl/ag_video_shifter.sv
// Pixel serialiser: loads a 16-bit RAM word with its bytes swapped so the
// even byte leads, then emits 1-bit or 2-bit pixels MSB first, zero filling.
module ag_video_shifter
    import ag_video_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              mode,
    input  logic              blank,
    input  logic [DATA_W-1:0] data,
    output logic [1:0]        pix
);

    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] rest;
    logic [DATA_W-1:0] sr;
    logic [1:0]        head;

    // Select the word being consumed and split off its leading pixel.
    always_comb begin
        src = load ? {data[7:0], data[15:8]} : sr;
        if (mode == MODE_2BPP) begin
            head = src[15:14];
            rest = {src[13:0], 2'b00};
        end else begin
            head = {1'b0, src[15]};
            rest = {src[14:0], 1'b0};
        end
    end

    // Advance one pixel per clock; the pixel register is cleared while blanked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr  <= '0;
            pix <= '0;
        end else begin
            sr  <= rest;
            pix <= blank ? 2'b00 : head;
        end
    end

endmodule

// File: rtl/ag_video_fetch.sv
// Video-side reader of the dual-port video RAM: raster counters, a fetch
// scheduler running two pixels ahead, per-frame MODE/PAGE latch and
// registered blank/sync/pixel outputs describing the current (h,v).
module ag_video_fetch
    import ag_video_fetch_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_TOTAL    = H_TOTAL_DEF,
    parameter int unsigned H_SYNC_ST  = H_SYNC_ST_DEF,
    parameter int unsigned H_SYNC_LEN = H_SYNC_LEN_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_TOTAL    = V_TOTAL_DEF,
    parameter int unsigned V_SYNC_ST  = V_SYNC_ST_DEF,
    parameter int unsigned V_SYNC_LEN = V_SYNC_LEN_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MODE,
    input  logic [1:0]        PAGE,
    output logic [ADDR_W-1:0] AB2,
    output logic              CS2,
    input  logic [DATA_W-1:0] DO2,
    output logic [1:0]        PIX,
    output logic              BLANK,
    output logic              HSYNC_N,
    output logic              VSYNC_N,
    output logic              FRAME_START
);

    localparam int unsigned HW = cnt_width(H_TOTAL);
    localparam int unsigned VW = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_RST   = HW'(H_TOTAL - 4);
    localparam logic [HW-1:0] H_LATCH = HW'(H_TOTAL - 2);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS    = HW'(H_SYNC_ST);
    localparam logic [HW-1:0] H_SE    = HW'(H_SYNC_ST + H_SYNC_LEN);
    localparam logic [HW:0]   H_TOT_X = (HW+1)'(H_TOTAL);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS    = VW'(V_SYNC_ST);
    localparam logic [VW-1:0] V_SE    = VW'(V_SYNC_ST + V_SYNC_LEN);

    logic [HW-1:0]     h_q, h_nxt, f_pos;
    logic [VW-1:0]     v_q, v_nxt, f_line;
    logic [HW:0]       f_sum;
    logic              f_wrap;
    logic              latch_now;
    logic              mode_q, mode_eff;
    logic [1:0]        page_q, page_eff;
    logic              aligned, fetch, fetch_d;
    logic [ADDR_W-1:0] addr;
    logic              blank_nxt;

    // Every output register is computed from the position of the coming
    // cycle, so after the edge it describes the counters it sits beside.
    always_comb begin
        h_nxt = (h_q == H_LAST) ? '0 : h_q + HW'(1);
        v_nxt = v_q;
        if (h_q == H_LAST) begin
            v_nxt = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
        f_sum  = {1'b0, h_nxt} + (HW+1)'(2);
        f_wrap = (f_sum >= H_TOT_X);
        f_pos  = f_wrap ? HW'(f_sum - H_TOT_X) : f_sum[HW-1:0];
        f_line = v_nxt;
        if (f_wrap) begin
            f_line = (v_nxt == V_LAST) ? '0 : v_nxt + VW'(1);
        end
        // The first fetch of a frame already uses the freshly latched MODE/PAGE.
        latch_now = (h_nxt == H_LATCH) && (v_nxt == V_LAST);
        mode_eff  = latch_now ? MODE : mode_q;
        page_eff  = latch_now ? PAGE : page_q;
        aligned   = (mode_eff == MODE_2BPP) ? (f_pos[2:0] == 3'b000)
                                            : (f_pos[3:0] == 4'b0000);
        fetch     = aligned && (f_pos < H_ACT) && (f_line < V_ACT);
        addr      = (mode_eff == MODE_2BPP) ? {page_eff[0], f_line[7:0], f_pos[7:3]}
                                            : {page_eff,    f_line[7:0], f_pos[7:4]};
        blank_nxt = !((h_nxt < H_ACT) && (v_nxt < V_ACT));
    end

    // Raster counters, fetch strobe/address, frame latch and sync/blank outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            h_q         <= H_RST;
            v_q         <= V_LAST;
            CS2         <= 1'b0;
            AB2         <= '0;
            fetch_d     <= 1'b0;
            mode_q      <= MODE_1BPP;
            page_q      <= '0;
            BLANK       <= 1'b1;
            HSYNC_N     <= 1'b1;
            VSYNC_N     <= 1'b1;
            FRAME_START <= 1'b0;
        end else begin
            h_q     <= h_nxt;
            v_q     <= v_nxt;
            CS2     <= fetch;
            fetch_d <= CS2;
            if (fetch) begin
                AB2 <= addr;
            end
            if (latch_now) begin
                mode_q <= MODE;
                page_q <= PAGE;
            end
            BLANK       <= blank_nxt;
            HSYNC_N     <= !((h_nxt >= H_SS) && (h_nxt < H_SE));
            VSYNC_N     <= !((v_nxt >= V_SS) && (v_nxt < V_SE));
            FRAME_START <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    // DO2 is valid the cycle after CS2; fetch_d marks that cycle as the load.
    ag_video_shifter u_shifter (
        .clk   (CLK),
        .rst_n (RST_N),
        .load  (fetch_d),
        .mode  (mode_q),
        .blank (blank_nxt),
        .data  (DO2),
        .pix   (PIX)
    );

endmodule

// File: tb/tb_ag_video_fetch.sv
// Directed bench for ag_video_fetch with a reduced vertical raster, a
// registered RAM model on port 2 and a pixel scoreboard queue.
module tb_ag_video_fetch;

    localparam int HT  = 384;
    localparam int HA  = 256;
    localparam int HSL = 32;
    localparam int VA  = 8;
    localparam int VT  = 14;
    localparam int VSS = 10;
    localparam int VSL = 2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MODE;
    logic [1:0]  PAGE;
    logic [13:0] AB2;
    logic        CS2;
    logic [15:0] DO2;
    logic [1:0]  PIX;
    logic        BLANK, HSYNC_N, VSYNC_N, FRAME_START;

    logic [15:0] mem [0:16383];
    logic [1:0]  sb [$];

    int total = 0;
    int bad   = 0;
    int hm = 0, vm = 0;
    int cnt_cs, cnt_hs, cnt_vs, cnt_blank_err, cnt_pix_err;

    // Expected pixel streams for the words placed in RAM.
    logic [1:0] exp_a55a_m0 [16] = '{0,1,0,1,1,0,1,0,1,0,1,0,0,1,0,1};
    logic [1:0] exp_1be4_m1 [8]  = '{3,2,1,0,0,1,2,3};
    logic [1:0] exp_1be4_m0 [16] = '{1,1,1,0,0,1,0,0,0,0,0,1,1,0,1,1};

    ag_video_fetch #(
        .V_ACTIVE   (VA),
        .V_TOTAL    (VT),
        .V_SYNC_ST  (VSS),
        .V_SYNC_LEN (VSL)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .MODE        (MODE),
        .PAGE        (PAGE),
        .AB2         (AB2),
        .CS2         (CS2),
        .DO2         (DO2),
        .PIX         (PIX),
        .BLANK       (BLANK),
        .HSYNC_N     (HSYNC_N),
        .VSYNC_N     (VSYNC_N),
        .FRAME_START (FRAME_START)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read RAM: data appears the cycle after CS2.
    always @(posedge CLK) begin
        if (CS2) DO2 <= mem[AB2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (h=%0d v=%0d)", tag, obs, exp, hm, vm);
        end
    endtask

    // One clock; the bench's own raster position follows the reset seen at the edge.
    task automatic tick();
        logic r;
        r = RST_N;
        @(posedge CLK);
        #1;
        if (!r) begin
            hm = HT - 4;
            vm = VT - 1;
        end else if (hm == HT - 1) begin
            hm = 0;
            vm = (vm == VT - 1) ? 0 : vm + 1;
        end else begin
            hm++;
        end
    endtask

    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        while (!(hm == h && vm == v) && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) chk("goto_timeout", 32'(n), 0);
    endtask

    task automatic clr();
        cnt_cs = 0; cnt_hs = 0; cnt_vs = 0; cnt_blank_err = 0; cnt_pix_err = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            logic       exp_blank;
            logic [1:0] e;
            exp_blank = !(hm < HA && vm < VA);
            if (CS2) cnt_cs++;
            if (!HSYNC_N) cnt_hs++;
            if (!VSYNC_N) cnt_vs++;
            if (BLANK !== exp_blank) cnt_blank_err++;
            if (BLANK && PIX !== 2'b00) cnt_pix_err++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pix", 32'(PIX), 32'(e));
            end
            tick();
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cs2"},   32'(CS2), 0);
        chk({tag, "_ab2"},   32'(AB2), 0);
        chk({tag, "_pix"},   32'(PIX), 0);
        chk({tag, "_blank"}, 32'(BLANK), 1);
        chk({tag, "_hs"},    32'(HSYNC_N), 1);
        chk({tag, "_vs"},    32'(VSYNC_N), 1);
        chk({tag, "_fs"},    32'(FRAME_START), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        mem[14'h2000] = 16'hA55A;
        RST_N = 1'b0; MODE = 1'b0; PAGE = 2'd0;

        // Reset values, then FRAME_START latency and the prefetch at (H_TOTAL-2, V_TOTAL-1).
        repeat (3) tick();
        check_reset("rst");
        RST_N = 1'b1;
        n = 0;
        while (FRAME_START !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (n == 2) begin
                chk("first_cs2", 32'(CS2), 1);
                chk("first_ab2", 32'(AB2), 0);
            end
        end
        chk("fs_latency", 32'(n), 4);

        // MODE0 PAGE2: word A55A at 0x2000 on line 0, 16 fetches per line.
        PAGE = 2'd2; MODE = 1'b0;
        goto(HT - 2, VT - 1);
        chk("m0_cs2", 32'(CS2), 1);
        chk("m0_ab2", 32'(AB2), 32'h2000);
        for (int i = 0; i < 16; i++) sb.push_back(exp_a55a_m0[i]);
        tick(); tick();
        chk("m0_fs", 32'(FRAME_START), 1);
        clr();
        run(HT);
        chk("m0_line_cs", 32'(cnt_cs), 16);
        chk("line_hs", 32'(cnt_hs), HSL);
        chk("m0_line_blank", 32'(cnt_blank_err), 0);

        // Last fetch of the last active line, then a fetch-free vertical blank.
        goto(238, VA - 1);
        chk("last_cs2", 32'(CS2), 1);
        chk("last_ab2", 32'(AB2), 32'h2000 | ((VA - 1) << 4) | 32'hF);
        goto(0, VA);
        clr();
        run((VT - 1 - VA) * HT + HT - 2);
        chk("vb_cs", 32'(cnt_cs), 0);
        chk("vb_blank", 32'(cnt_blank_err), 0);
        chk("vb_pix", 32'(cnt_pix_err), 0);
        chk("vb_vs", 32'(cnt_vs), VSL * HT);

        // Mid-frame MODE/PAGE change only applies from the next frame.
        goto(0, 4);
        MODE = 1'b1; PAGE = 2'd1;
        goto(6, 5);
        chk("tog_cs2_h6", 32'(CS2), 0);
        goto(14, 5);
        chk("tog_cs2_h14", 32'(CS2), 1);
        chk("tog_ab2_h14", 32'(AB2), 32'h2051);
        mem[14'h2000] = 16'h1BE4;
        goto(HT - 2, VT - 1);
        chk("m1_cs2", 32'(CS2), 1);
        chk("m1_ab2", 32'(AB2), 32'h2000);
        for (int i = 0; i < 8; i++) sb.push_back(exp_1be4_m1[i]);
        tick(); tick();
        chk("m1_fs", 32'(FRAME_START), 1);
        clr();
        run(HT);
        chk("m1_line_cs", 32'(cnt_cs), 32);
        goto(6, 1);
        chk("m1_cs2_h6", 32'(CS2), 1);
        chk("m1_ab2_h6", 32'(AB2), 32'h2021);

        // One-cycle reset mid-line, mid-frame, then a clean full frame.
        goto(50, 3);
        RST_N = 1'b0; MODE = 1'b0; PAGE = 2'd2;
        tick();
        check_reset("midrst");
        RST_N = 1'b1;
        for (int i = 0; i < 16; i++) sb.push_back(exp_1be4_m0[i]);
        n = 0;
        while (FRAME_START !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("fs_latency2", 32'(n), 4);
        clr();
        run(VT * HT);
        chk("frame_cs", 32'(cnt_cs), 16 * VA);
        chk("frame_hs", 32'(cnt_hs), VT * HSL);
        chk("frame_vs", 32'(cnt_vs), VSL * HT);
        chk("frame_blank", 32'(cnt_blank_err), 0);
        chk("frame_pix", 32'(cnt_pix_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
